// File: rtl/inst_fetch_queue_if.sv
// Fetch-packet / decode handshake bundle for inst_fetch_queue.
// The master side is the fetch and decode logic; the slave side is the queue.
interface inst_fetch_queue_if #(
    parameter int PTR_W = 3
);
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_pc;
    logic [127:0] in_inst;
    logic [2:0]   in_cnt;
    logic         out0_valid;
    logic [63:0]  out0_pc;
    logic [31:0]  out0_inst;
    logic         out0_is_ctrl;
    logic         out1_valid;
    logic [63:0]  out1_pc;
    logic [31:0]  out1_inst;
    logic         out1_is_ctrl;
    logic [1:0]   deq_num;
    logic [PTR_W:0] count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_cnt, deq_num,
        input  in_ready, out0_valid, out0_pc, out0_inst, out0_is_ctrl,
               out1_valid, out1_pc, out1_inst, out1_is_ctrl, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_cnt, deq_num,
        output in_ready, out0_valid, out0_pc, out0_inst, out0_is_ctrl,
               out1_valid, out1_pc, out1_inst, out1_is_ctrl, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue: 1-4 instructions in per cycle, up to 2 out per cycle.
// Define IFQ_PREDECODE_EN to store and drive a per-entry control-transfer flag.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input logic clk,
    input logic rst,
    inst_fetch_queue_if.slave bus
);
    logic [63:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head1;
    logic [PTR_W:0]   count_q;
    logic             cnt_legal;
    logic             enq_fire;
    logic [PTR_W:0]   enq_cnt;
    logic [PTR_W:0]   deq_req;
    logic [PTR_W:0]   deq_eff;
    logic [PTR_W-1:0] wr_idx [4];
    logic             wr_en  [4];

    // Ready looks only at the registered count, so a same-cycle dequeue never frees space early.
    assign bus.in_ready = (count_q <= (PTR_W+1)'(DEPTH - 4));
    assign head1        = head + PTR_W'(1);

    always_comb begin
        cnt_legal = (bus.in_cnt != 3'd0) && (bus.in_cnt <= 3'd4);
        enq_fire  = bus.in_valid && bus.in_ready && !bus.flush && cnt_legal;
        enq_cnt   = enq_fire ? (PTR_W+1)'(bus.in_cnt) : '0;
        deq_req   = (PTR_W+1)'(bus.deq_num);
        deq_eff   = (deq_req > count_q) ? count_q : deq_req;
        for (int k = 0; k < 4; k++) begin
            wr_idx[k] = tail + PTR_W'(k);
            wr_en[k]  = enq_fire && (3'(k) < bus.in_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + deq_eff[PTR_W-1:0];
            tail    <= tail + enq_cnt[PTR_W-1:0];
            count_q <= count_q + enq_cnt - deq_eff;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst && wr_en[k]) begin
                pc_mem[wr_idx[k]]   <= bus.in_pc + 64'(4 * k);
                inst_mem[wr_idx[k]] <= bus.in_inst[32*k +: 32];
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.out0_valid = (count_q != '0);
    assign bus.out1_valid = (count_q > (PTR_W+1)'(1));
    assign bus.out0_pc    = bus.out0_valid ? pc_mem[head]    : '0;
    assign bus.out0_inst  = bus.out0_valid ? inst_mem[head]  : '0;
    assign bus.out1_pc    = bus.out1_valid ? pc_mem[head1]   : '0;
    assign bus.out1_inst  = bus.out1_valid ? inst_mem[head1] : '0;

`ifdef IFQ_PREDECODE_EN
    logic [DEPTH-1:0] ctrl_mem;

    // Full-length encoding with a JAL, JALR or BRANCH major opcode.
    function automatic logic is_ctrl_op(input logic [31:0] inst);
        return (inst[1:0] == 2'b11) &&
               ((inst[6:2] == 5'b11011) || (inst[6:2] == 5'b11001) || (inst[6:2] == 5'b11000));
    endfunction

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst && wr_en[k]) begin
                ctrl_mem[wr_idx[k]] <= is_ctrl_op(bus.in_inst[32*k +: 32]);
            end
        end
    end

    assign bus.out0_is_ctrl = bus.out0_valid && ctrl_mem[head];
    assign bus.out1_is_ctrl = bus.out1_valid && ctrl_mem[head1];
`else
    assign bus.out0_is_ctrl = 1'b0;
    assign bus.out1_is_ctrl = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a queue-based model checked every cycle,
// plus literal expectations after each directed step.
module tb_inst_fetch_queue;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
`ifdef IFQ_PREDECODE_EN
    localparam bit PREDEC = 1'b1;
`else
    localparam bit PREDEC = 1'b0;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    bit   checking;
    ent_t mq[$];
    int   m_sz;
    int   m_deq;
    bit   m_rdy;

    inst_fetch_queue_if #(.PTR_W(PTR_W)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic predecode(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic fl, input logic v, input logic [63:0] pc,
                                 input logic [2:0] cnt, input logic [127:0] inst, input logic [1:0] deq);
        rst          = r;
        bus.flush    = fl;
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_cnt   = cnt;
        bus.in_inst  = inst;
        bus.deq_num  = deq;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain instruction queue following the enqueue/dequeue rules.
    always @(posedge clk) begin
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            m_sz  = mq.size();
            m_deq = (int'(bus.deq_num) > m_sz) ? m_sz : int'(bus.deq_num);
            m_rdy = (DEPTH - m_sz) >= 4;
            repeat (m_deq) void'(mq.pop_front());
            if (bus.in_valid && m_rdy && bus.in_cnt >= 3'd1 && bus.in_cnt <= 3'd4) begin
                for (int k = 0; k < int'(bus.in_cnt); k++) begin
                    mq.push_back('{pc: bus.in_pc + 64'(4 * k), inst: bus.in_inst[32*k +: 32]});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("count", 64'(bus.count), 64'(mq.size()));
            checkOutput("in_ready", 64'(bus.in_ready), 64'((DEPTH - mq.size()) >= 4));
            checkOutput("out0_valid", 64'(bus.out0_valid), 64'(mq.size() >= 1));
            checkOutput("out1_valid", 64'(bus.out1_valid), 64'(mq.size() >= 2));
            checkOutput("out0_pc", bus.out0_pc, (mq.size() >= 1) ? mq[0].pc : 64'd0);
            checkOutput("out0_inst", 64'(bus.out0_inst), (mq.size() >= 1) ? 64'(mq[0].inst) : 64'd0);
            checkOutput("out1_pc", bus.out1_pc, (mq.size() >= 2) ? mq[1].pc : 64'd0);
            checkOutput("out1_inst", 64'(bus.out1_inst), (mq.size() >= 2) ? 64'(mq[1].inst) : 64'd0);
            checkOutput("out0_is_ctrl", 64'(bus.out0_is_ctrl),
                        64'(PREDEC && mq.size() >= 1 && predecode(mq[0].inst)));
            checkOutput("out1_is_ctrl", 64'(bus.out1_is_ctrl),
                        64'(PREDEC && mq.size() >= 2 && predecode(mq[1].inst)));
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        checking    = 1'b0;
        applyStimulus(1, 0, 0, 64'd0, 3'd0, 128'd0, 2'd0);
        checking    = 1'b1;
        applyStimulus(1, 0, 0, 64'd0, 3'd0, 128'd0, 2'd0);
        checkOutput("reset count", 64'(bus.count), 64'd0);
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset out0_valid", 64'(bus.out0_valid), 64'd0);
        checkOutput("reset out1_valid", 64'(bus.out1_valid), 64'd0);

        applyStimulus(0, 0, 1, 64'h8000_0000, 3'd4,
                      {32'h0030_0193, 32'h0020_0113, 32'h0010_0093, 32'h0000_0013}, 2'd0);
        checkOutput("push4 count", 64'(bus.count), 64'd4);
        checkOutput("push4 out0_pc", bus.out0_pc, 64'h8000_0000);
        checkOutput("push4 out0_inst", 64'(bus.out0_inst), 64'h0000_0013);
        checkOutput("push4 out1_pc", bus.out1_pc, 64'h8000_0004);
        checkOutput("push4 out1_inst", 64'(bus.out1_inst), 64'h0010_0093);
        checkOutput("push4 in_ready", 64'(bus.in_ready), 64'd1);

        applyStimulus(0, 0, 1, 64'h8000_0010, 3'd3,
                      {32'h0, 32'h0060_0313, 32'h0050_0293, 32'h0040_0213}, 2'd2);
        checkOutput("enq+deq count", 64'(bus.count), 64'd5);
        checkOutput("enq+deq out0_pc", bus.out0_pc, 64'h8000_0008);
        checkOutput("enq+deq out1_pc", bus.out1_pc, 64'h8000_000C);

        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        checkOutput("drain count", 64'(bus.count), 64'd1);
        checkOutput("drain out0_pc", bus.out0_pc, 64'h8000_0018);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        checkOutput("clamp count", 64'(bus.count), 64'd0);
        checkOutput("clamp out0_valid", 64'(bus.out0_valid), 64'd0);
        applyStimulus(0, 0, 1, 64'h1234_0000, 3'd1, {96'd0, 32'h0070_0393}, 2'd0);
        checkOutput("after clamp out0_pc", bus.out0_pc, 64'h1234_0000);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd1);

        applyStimulus(0, 0, 1, 64'hA000_0000, 3'd4, {4{32'h0000_0013}}, 2'd0);
        applyStimulus(0, 0, 1, 64'hA000_0010, 3'd2, {4{32'h0010_0093}}, 2'd0);
        checkOutput("pre-flush count", 64'(bus.count), 64'd6);
        applyStimulus(0, 1, 1, 64'hC000_0000, 3'd4, {4{32'h0020_0113}}, 2'd1);
        checkOutput("flush count", 64'(bus.count), 64'd0);
        checkOutput("flush out0_valid", 64'(bus.out0_valid), 64'd0);
        checkOutput("flush out1_valid", 64'(bus.out1_valid), 64'd0);
        checkOutput("flush in_ready", 64'(bus.in_ready), 64'd1);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd0);
        checkOutput("flush dropped", 64'(bus.count), 64'd0);

        applyStimulus(0, 0, 1, 64'h9000_0000, 3'd4,
                      {32'h00D0_0013, 32'h00C0_0013, 32'h00B0_0013, 32'h00A0_0013}, 2'd0);
        applyStimulus(0, 0, 1, 64'h9000_0010, 3'd4,
                      {32'h0110_0013, 32'h0100_0013, 32'h00F0_0013, 32'h00E0_0013}, 2'd0);
        checkOutput("full count", 64'(bus.count), 64'd8);
        checkOutput("full in_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(0, 0, 1, 64'hDEAD_0000, 3'd4, {4{32'hDEAD_BEEF}}, 2'd0);
        checkOutput("full push ignored", 64'(bus.count), 64'd8);
        checkOutput("full out0_pc", bus.out0_pc, 64'h9000_0000);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        checkOutput("count6 in_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        checkOutput("count4 in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("head4 out0_pc", bus.out0_pc, 64'h9000_0010);
        checkOutput("head4 out0_inst", 64'(bus.out0_inst), 64'h00E0_0013);

        applyStimulus(0, 0, 1, 64'hB000_0000, 3'd4,
                      {32'h0150_0013, 32'h0140_0013, 32'h0130_0013, 32'h0120_0013}, 2'd0);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        checkOutput("wrap out0_pc", bus.out0_pc, 64'hB000_0000);
        checkOutput("wrap out1_inst", 64'(bus.out1_inst), 64'h0130_0013);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);

        applyStimulus(0, 0, 1, 64'h5000, 3'd0, {4{32'h0000_0013}}, 2'd0);
        checkOutput("cnt0 ignored", 64'(bus.count), 64'd0);
        applyStimulus(0, 0, 1, 64'h5000, 3'd5, {4{32'h0000_0013}}, 2'd0);
        checkOutput("cnt5 ignored", 64'(bus.count), 64'd0);

        applyStimulus(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 3'd4,
                      {32'h0000_0073, 32'h0000_0033, 32'h0000_0023, 32'h0000_0003}, 2'd0);
        checkOutput("pcwrap out1_pc", bus.out1_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        checkOutput("pcwrap out0_pc", bus.out0_pc, 64'h0);
        checkOutput("pcwrap out1_pc2", bus.out1_pc, 64'h4);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);

        applyStimulus(0, 0, 1, 64'h100, 3'd2, {64'd0, 32'h0000_0013, 32'h0000_006F}, 2'd0);
        checkOutput("jal out0_is_ctrl", 64'(bus.out0_is_ctrl), 64'(PREDEC));
        checkOutput("addi out1_is_ctrl", 64'(bus.out1_is_ctrl), 64'd0);
        applyStimulus(0, 0, 1, 64'h200, 3'd4,
                      {32'h0000_006C, 32'h0000_006B, 32'h0020_8463, 32'h0000_8067}, 2'd2);
        checkOutput("jalr out0_is_ctrl", 64'(bus.out0_is_ctrl), 64'(PREDEC));
        checkOutput("branch out1_is_ctrl", 64'(bus.out1_is_ctrl), 64'(PREDEC));
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd2);
        checkOutput("op6b out0_is_ctrl", 64'(bus.out0_is_ctrl), 64'd0);
        checkOutput("op6c out1_is_ctrl", 64'(bus.out1_is_ctrl), 64'd0);

        applyStimulus(1, 1, 1, 64'h300, 3'd4, {4{32'h0000_0013}}, 2'd0);
        checkOutput("rst+flush count", 64'(bus.count), 64'd0);
        applyStimulus(0, 0, 0, 64'd0, 3'd0, 128'd0, 2'd0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
